// File: rtl/hvsync_pkg.sv
// Shared raster timing constants and coordinate type for the hvsync generator.
package hvsync_pkg;

    localparam int H_DISPLAY = 256;
    localparam int H_BACK    = 23;
    localparam int H_FRONT   = 7;
    localparam int H_SYNC    = 23;
    localparam int V_DISPLAY = 240;
    localparam int V_TOP     = 5;
    localparam int V_BOTTOM  = 14;
    localparam int V_SYNC    = 3;

    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int H_MAX        = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam int V_SYNC_END   = V_DISPLAY + V_BOTTOM + V_SYNC - 1;
    localparam int V_MAX        = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;

    typedef logic [8:0] coord_t;

endpackage

// File: rtl/hvsync_if.sv
// Video timing bundle: the generator drives it, pixel renderers consume it.
interface hvsync_if;
    import hvsync_pkg::*;

    logic   hsync;
    logic   vsync;
    logic   display_on;
    coord_t hpos;
    coord_t vpos;

    modport master (output hsync, output vsync, output display_on, output hpos, output vpos);
    modport slave  (input hsync, input vsync, input display_on, input hpos, input vpos);
endinterface

// File: rtl/hvsync_generator_raster_counter.sv
// Modulo counter (0..MAX) with synchronous clear and increment enable.
module raster_counter
    import hvsync_pkg::*;
#(
    parameter int MAX = 511
) (
    input  logic   clk,
    input  logic   clear,
    input  logic   enable,
    output coord_t count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == coord_t'(MAX)) ? '0 : count + 9'd1;
        end
    end

endmodule

// File: rtl/hvsync_generator.sv
// Free-running raster timing generator. Define HVSYNC_ACTIVE_LOW_EN for
// active-low hsync/vsync; default build drives active-high sync pulses.
module hvsync_generator
    import hvsync_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    hvsync_if.master vid
);

    if (H_MAX > 511 || V_MAX > 511) begin : g_range_check
        $error("hvsync_generator: H_MAX/V_MAX exceed 9-bit coordinate range");
    end

`ifdef HVSYNC_ACTIVE_LOW_EN
    localparam logic SYNC_IDLE = 1'b1;
`else
    localparam logic SYNC_IDLE = 1'b0;
`endif

    coord_t hpos;
    coord_t vpos;
    logic   hmaxxed;
    logic   hsync_q;
    logic   vsync_q;
    logic   h_window;
    logic   v_window;

    assign hmaxxed = (hpos == coord_t'(H_MAX));

    raster_counter #(.MAX(H_MAX)) u_hcount (
        .clk    (clk),
        .clear  (reset),
        .enable (1'b1),
        .count  (hpos)
    );

    raster_counter #(.MAX(V_MAX)) u_vcount (
        .clk    (clk),
        .clear  (reset),
        .enable (hmaxxed),
        .count  (vpos)
    );

    // Windows decode the pre-edge position, so the sync outputs lag by one clock.
    assign h_window = (hpos >= coord_t'(H_SYNC_START)) && (hpos <= coord_t'(H_SYNC_END));
    assign v_window = (vpos >= coord_t'(V_SYNC_START)) && (vpos <= coord_t'(V_SYNC_END));

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
        end else begin
            hsync_q <= h_window ? ~SYNC_IDLE : SYNC_IDLE;
            vsync_q <= v_window ? ~SYNC_IDLE : SYNC_IDLE;
        end
    end

    assign vid.hpos       = hpos;
    assign vid.vpos       = vpos;
    assign vid.hsync      = hsync_q;
    assign vid.vsync      = vsync_q;
    assign vid.display_on = (hpos < coord_t'(H_DISPLAY)) && (vpos < coord_t'(V_DISPLAY));

endmodule

// File: tb/tb_hvsync_generator.sv
// Directed bench for hvsync_generator: line/frame timing, sync windows,
// display_on boundaries and mid-frame reset.
module tb_hvsync_generator;

    localparam int LINE  = 309;
    localparam int FRAME = 309 * 262;

`ifdef HVSYNC_ACTIVE_LOW_EN
    localparam logic IDLE = 1'b1;
`else
    localparam logic IDLE = 1'b0;
`endif
    localparam logic ACT = ~IDLE;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    int   cur_idx;
    int   cnt;

    hvsync_if vid ();

    hvsync_generator dut (
        .clk   (clk),
        .reset (reset),
        .vid   (vid)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks and sample on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        cur_idx = (cur_idx + n) % FRAME;
    endtask

    task automatic go_to(input int h, input int v);
        int target;
        int n;
        target = v * LINE + h;
        n = (target >= cur_idx) ? target - cur_idx : target + FRAME - cur_idx;
        step(n);
        check($sformatf("hpos@(%0d,%0d)", h, v), vid.hpos, 9'(h));
        check($sformatf("vpos@(%0d,%0d)", h, v), vid.vpos, 9'(v));
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cur_idx = 0;
        check({tag, "_hpos"}, vid.hpos, 9'd0);
        check({tag, "_vpos"}, vid.vpos, 9'd0);
        check({tag, "_hsync"}, 9'(vid.hsync), 9'(IDLE));
        check({tag, "_vsync"}, 9'(vid.vsync), 9'(IDLE));
        check({tag, "_disp"}, 9'(vid.display_on), 9'd1);
        reset = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cur_idx    = 0;
        reset      = 1'b1;
        @(posedge clk);
        pulse_reset("reset");

        step(1);
        check("first_hpos", vid.hpos, 9'd1);
        check("first_vpos", vid.vpos, 9'd0);
        check("first_hsync", 9'(vid.hsync), 9'(IDLE));
        check("first_vsync", 9'(vid.vsync), 9'(IDLE));
        check("first_disp", 9'(vid.display_on), 9'd1);

        // Horizontal sync window edges
        go_to(263, 0); check("hsync@263", 9'(vid.hsync), 9'(IDLE));
        go_to(264, 0); check("hsync@264", 9'(vid.hsync), 9'(ACT));
        go_to(286, 0); check("hsync@286", 9'(vid.hsync), 9'(ACT));
        go_to(287, 0); check("hsync@287", 9'(vid.hsync), 9'(IDLE));

        cnt = 0;
        for (int i = 0; i < LINE; i++) begin
            step(1);
            if (vid.hsync === ACT) cnt++;
        end
        check("hsync_width", 9'(cnt), 9'd23);

        // Line wrap
        go_to(308, 1);
        go_to(0, 2);

        // display_on boundaries
        go_to(255, 239); check("disp@(255,239)", 9'(vid.display_on), 9'd1);
        go_to(256, 239); check("disp@(256,239)", 9'(vid.display_on), 9'd0);
        go_to(0, 240);   check("disp@(0,240)", 9'(vid.display_on), 9'd0);

        // Vertical sync window
        go_to(0, 254); check("vsync@(0,254)", 9'(vid.vsync), 9'(IDLE));
        go_to(1, 254); check("vsync@(1,254)", 9'(vid.vsync), 9'(ACT));
        cnt = 1;
        for (int i = 0; i < 3 * LINE + 1; i++) begin
            step(1);
            if (vid.vsync === ACT) cnt++;
        end
        check("vsync_width", 9'(cnt >> 1), 9'(927 >> 1));
        check("vsync_width_lsb", 9'(cnt & 1), 9'(927 & 1));
        check("vsync@(2,257)", 9'(vid.vsync), 9'(IDLE));

        // Frame wrap
        go_to(308, 261);
        go_to(0, 0);
        check("disp@(0,0)", 9'(vid.display_on), 9'd1);
        check("hsync@(0,0)", 9'(vid.hsync), 9'(IDLE));

        // Reset during an active hsync pulse
        go_to(270, 0); check("hsync@(270,0)", 9'(vid.hsync), 9'(ACT));
        pulse_reset("rst_in_hsync");
        step(1);
        check("restart1_hpos", vid.hpos, 9'd1);

        // Reset mid-frame
        go_to(150, 10);
        pulse_reset("rst_mid");
        step(1);
        check("restart2_hpos", vid.hpos, 9'd1);
        check("restart2_vpos", vid.vpos, 9'd0);
        go_to(308, 0);
        go_to(0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
